multicycle_ctrl: RTL and testbench

- Multi-cycle RV32I control FSM.
- Drives the ALU's 4-bit operation select plus all datapath mux selects and write strobes. It is the initiating end of the ALU interface.
- Consumes opcode/funct fields from the instruction register and the ALU `zero` flag.
- Sequences fetch/decode/execute/memory/writeback, stalling on a memory ready handshake.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/alu_op_decoder.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
// CTRL_ILLEGAL_TRAP_EN adds the sticky TRAP state.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd15
`endif
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       adr_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
  } ctrl_out_t;

  // funct3 010/011 have no branch meaning in RV32I
  function automatic logic branch_f3_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational funct3/funct7b5 to ALU operation decode for R- and I-type ALU instructions.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  logic is_rtype_s;

  assign is_rtype_s = (op == OP_RTYPE);

  // bit 30 only means SUB on R-type; on addi it is immediate data
  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (is_rtype_s && funct7b5) begin
          alu_control = ALU_SUB;
        end else begin
          alu_control = ALU_ADD;
        end
      end
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: begin
        if (funct7b5) begin
          alu_control = ALU_SRA;
        end else begin
          alu_control = ALU_SRL;
        end
      end
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal instructions instead of retiring them as NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALUcontrol,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_DEST = S_TRAP;
`else
  localparam state_t ILLEGAL_DEST = S_FETCH;
`endif

  state_t    state_r;
  state_t    state_next_s;
  logic [3:0] decoded_op_s;
  logic      illegal_op_s;
  ctrl_out_t out_s;
  ctrl_out_t gated_s;

  alu_op_decoder u_alu_op_decoder (
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (decoded_op_s)
  );

  // classify the instruction held in the IR as legal or not
  always_comb begin
    illegal_op_s = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_op_s = 1'b0;
      OP_BRANCH: illegal_op_s = branch_f3_illegal(funct3);
      default:   illegal_op_s = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (illegal_op_s) begin
          state_next_s = ILLEGAL_DEST;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
            OP_RTYPE:          state_next_s = S_EXECR;
            OP_ITYPE:          state_next_s = S_EXECI;
            OP_BRANCH:         state_next_s = S_BRANCH;
            OP_JAL:            state_next_s = S_JAL;
            OP_JALR:           state_next_s = S_JALR;
            OP_LUI:            state_next_s = S_LUI;
            OP_AUIPC:          state_next_s = S_AUIPC;
            default:           state_next_s = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        if (op == OP_LOAD) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMWB:  state_next_s = S_FETCH;
      S_EXECR:  state_next_s = S_ALUWB;
      S_EXECI:  state_next_s = S_ALUWB;
      S_ALUWB:  state_next_s = S_FETCH;
      S_BRANCH: state_next_s = S_FETCH;
      S_JAL:    state_next_s = S_ALUWB;
      S_JALR:   state_next_s = S_JLINK;
      S_JLINK:  state_next_s = S_ALUWB;
      S_LUI:    state_next_s = S_ALUWB;
      S_AUIPC:  state_next_s = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_next_s = S_TRAP;
`endif
      default:  state_next_s = S_FETCH;
    endcase
  end

  // per-state datapath controls; anything not named stays 0
  always_comb begin
    out_s = '0;
    case (state_r)
      S_FETCH: begin
        out_s.adr_src    = ADR_PC;
        out_s.mem_read   = 1'b1;
        out_s.alu_src_a  = SRCA_PC;
        out_s.alu_src_b  = SRCB_FOUR;
        out_s.result_src = RES_ALU;
        out_s.pc_write   = mem_ready;
        out_s.ir_write   = mem_ready;
      end
      S_DECODE: begin
        out_s.alu_src_a = SRCA_OLDPC;
        out_s.alu_src_b = SRCB_IMM;
        out_s.imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        out_s.alu_src_a = SRCA_RS1;
        out_s.alu_src_b = SRCB_IMM;
        out_s.imm_src   = (op == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD: begin
        out_s.adr_src  = ADR_RESULT;
        out_s.mem_read = 1'b1;
      end
      S_MEMWB: begin
        out_s.result_src = RES_RDATA;
        out_s.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        out_s.adr_src   = ADR_RESULT;
        out_s.mem_write = 1'b1;
      end
      S_EXECR: begin
        out_s.alu_src_a   = SRCA_RS1;
        out_s.alu_src_b   = SRCB_RS2;
        out_s.alu_control = decoded_op_s;
      end
      S_EXECI: begin
        out_s.alu_src_a   = SRCA_RS1;
        out_s.alu_src_b   = SRCB_IMM;
        out_s.imm_src     = IMM_I;
        out_s.alu_control = decoded_op_s;
      end
      S_ALUWB: begin
        out_s.result_src = RES_ALUOUT;
        out_s.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        out_s.alu_src_a  = SRCA_RS1;
        out_s.alu_src_b  = SRCB_RS2;
        out_s.result_src = RES_ALUOUT;
        // SLT/SLTU give 1 when "less", so zero means the ge-style condition holds
        case (funct3)
          3'b000: begin out_s.alu_control = ALU_SUB;  out_s.pc_write = zero;  end
          3'b001: begin out_s.alu_control = ALU_SUB;  out_s.pc_write = !zero; end
          3'b100: begin out_s.alu_control = ALU_SLT;  out_s.pc_write = !zero; end
          3'b101: begin out_s.alu_control = ALU_SLT;  out_s.pc_write = zero;  end
          3'b110: begin out_s.alu_control = ALU_SLTU; out_s.pc_write = !zero; end
          3'b111: begin out_s.alu_control = ALU_SLTU; out_s.pc_write = zero;  end
          default: begin out_s.alu_control = ALU_SUB; out_s.pc_write = 1'b0;  end
        endcase
      end
      S_JAL: begin
        out_s.pc_write   = 1'b1;
        out_s.result_src = RES_ALUOUT;
        out_s.alu_src_a  = SRCA_OLDPC;
        out_s.alu_src_b  = SRCB_FOUR;
      end
      S_JALR: begin
        out_s.alu_src_a  = SRCA_RS1;
        out_s.alu_src_b  = SRCB_IMM;
        out_s.imm_src    = IMM_I;
        out_s.result_src = RES_ALU;
        out_s.pc_write   = 1'b1;
      end
      S_JLINK: begin
        out_s.alu_src_a = SRCA_OLDPC;
        out_s.alu_src_b = SRCB_FOUR;
      end
      S_LUI: begin
        out_s.alu_src_a = SRCA_ZERO;
        out_s.alu_src_b = SRCB_IMM;
        out_s.imm_src   = IMM_U;
      end
      S_AUIPC: begin
        out_s.alu_src_a = SRCA_OLDPC;
        out_s.alu_src_b = SRCB_IMM;
        out_s.imm_src   = IMM_U;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        out_s.illegal = 1'b1;
      end
`endif
      default: out_s = '0;
    endcase
  end

  // reset forces every output low at once, so an in-flight access is dropped
  assign gated_s = reset ? '0 : out_s;

  assign ALUcontrol = gated_s.alu_control;
  assign ALUSrcA    = gated_s.alu_src_a;
  assign ALUSrcB    = gated_s.alu_src_b;
  assign ImmSrc     = gated_s.imm_src;
  assign ResultSrc  = gated_s.result_src;
  assign AdrSrc     = gated_s.adr_src;
  assign PCWrite    = gated_s.pc_write;
  assign IRWrite    = gated_s.ir_write;
  assign MemRead    = gated_s.mem_read;
  assign MemWrite   = gated_s.mem_write;
  assign RegWrite   = gated_s.reg_write;
  assign illegal    = gated_s.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, directed corner cases, randomized model run.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [1:0] res;
    logic       adr;
    logic       pcw;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         fst;
    int         mst;
    int         cyc;
    logic [3:0] alu3;
    logic       pcw3;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] ALUcontrol;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic       AdrSrc, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal;

  outs_t got;
  int    checks = 0;
  int    errors = 0;
  bit    force_ready = 1'b0;
  outs_t exp_q[$];
  bit    wait_q[$];
  int    kind_q[$];
  vec_t  vt[20];

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .ALUcontrol(ALUcontrol), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {ALUcontrol, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, AdrSrc,
                PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal};

  task automatic chk(input string name, input outs_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, e, $time);
    end
  endtask

  task automatic chk_int(input string name, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask

  // entered at posedge+1 with inputs driven; compares at the falling edge
  task automatic step_check(input string name, input outs_t e);
    #4;
    chk(name, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [3:0] base [8];
    base = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
    if (f3 == 3'd0 && f7 && is_r) return 4'b0001;
    if (f3 == 3'd5 && f7) return 4'b0111;
    return base[f3];
  endfunction

  function automatic outs_t ab(input logic [1:0] a, input logic [1:0] b,
                               input logic [2:0] imm, input logic [3:0] alu);
    outs_t e;
    e = '0;
    e.a = a; e.b = b; e.imm = imm; e.alu = alu;
    return e;
  endfunction

  task automatic push(input outs_t e, input bit w, input int k);
    exp_q.push_back(e);
    wait_q.push_back(w);
    kind_q.push_back(k);
  endtask

  // instruction -> list of per-cycle expectations (kind 1: fetch strobes, 2/3: branch on zero/!zero)
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    outs_t e, wb;
    exp_q.delete(); wait_q.delete(); kind_q.delete();
    wb = '0; wb.rw = 1'b1;
    e = ab(2'b00, 2'b10, 3'b000, 4'b0000); e.res = 2'b10; e.mr = 1'b1;
    push(e, 1'b1, 1);
    push(ab(2'b01, 2'b01, (o == 7'b1101111) ? 3'b011 : 3'b010, 4'b0000), 1'b0, 0);
    case (o)
      7'b0000011: begin
        push(ab(2'b10, 2'b01, 3'b000, 4'b0000), 1'b0, 0);
        e = '0; e.adr = 1'b1; e.mr = 1'b1; push(e, 1'b1, 0);
        e = '0; e.res = 2'b01; e.rw = 1'b1; push(e, 1'b0, 0);
      end
      7'b0100011: begin
        push(ab(2'b10, 2'b01, 3'b001, 4'b0000), 1'b0, 0);
        e = '0; e.adr = 1'b1; e.mw = 1'b1; push(e, 1'b1, 0);
      end
      7'b0110011: begin
        push(ab(2'b10, 2'b00, 3'b000, ref_alu(f3, f7, 1'b1)), 1'b0, 0);
        push(wb, 1'b0, 0);
      end
      7'b0010011: begin
        push(ab(2'b10, 2'b01, 3'b000, ref_alu(f3, f7, 1'b0)), 1'b0, 0);
        push(wb, 1'b0, 0);
      end
      7'b1100011: begin
        if (f3[2:1] != 2'b01) begin
          e = ab(2'b10, 2'b00, 3'b000, f3[2] ? (f3[1] ? 4'b1001 : 4'b1000) : 4'b0001);
          push(e, 1'b0, (f3[0] != f3[2]) ? 3 : 2);
        end
      end
      7'b1101111: begin
        e = ab(2'b01, 2'b10, 3'b000, 4'b0000); e.pcw = 1'b1;
        push(e, 1'b0, 0);
        push(wb, 1'b0, 0);
      end
      7'b1100111: begin
        e = ab(2'b10, 2'b01, 3'b000, 4'b0000); e.res = 2'b10; e.pcw = 1'b1;
        push(e, 1'b0, 0);
        push(ab(2'b01, 2'b10, 3'b000, 4'b0000), 1'b0, 0);
        push(wb, 1'b0, 0);
      end
      7'b0110111: begin
        push(ab(2'b11, 2'b01, 3'b100, 4'b0000), 1'b0, 0);
        push(wb, 1'b0, 0);
      end
      7'b0010111: begin
        push(ab(2'b01, 2'b01, 3'b100, 4'b0000), 1'b0, 0);
        push(wb, 1'b0, 0);
      end
      default: ;
    endcase
  endtask

  task automatic run_model(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7);
    outs_t e;
    int    waited;
    op = o; funct3 = f3; funct7b5 = f7;
    build(o, f3, f7);
    for (int i = 0; i < exp_q.size(); i++) begin
      waited = 0;
      do begin
        mem_ready = (force_ready || waited >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
        zero = 1'($urandom_range(0, 1));
        e = exp_q[i];
        if (kind_q[i] == 1) begin
          e.pcw = mem_ready; e.irw = mem_ready;
        end else if (kind_q[i] == 2) begin
          e.pcw = zero;
        end else if (kind_q[i] == 3) begin
          e.pcw = !zero;
        end
        step_check(name, e);
        waited++;
      end while (wait_q[i] && !mem_ready);
    end
  endtask

  // counts cycles until the next fetch, stalling fetch/memory states as the vector asks
  task automatic run_vec(input vec_t v);
    int   cyc, post, fs, ms;
    logic [3:0] alu3;
    logic pcw3;
    bit   fdone, ended;
    cyc = 0; post = -1; fs = v.fst; ms = v.mst; alu3 = 4'hf; pcw3 = 1'bx;
    fdone = 1'b0; ended = 1'b0;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
    while (!ended && cyc < 40) begin
      if (MemRead && !AdrSrc) begin
        if (fdone) begin
          ended = 1'b1;
          break;
        end
        mem_ready = (fs == 0); if (fs > 0) fs--;
      end else if ((MemRead && AdrSrc) || MemWrite) begin
        mem_ready = (ms == 0); if (ms > 0) ms--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #4;
      if (fdone) post++;
      if (post == 1) begin
        alu3 = ALUcontrol; pcw3 = PCWrite;
      end
      if (MemRead && !AdrSrc && mem_ready) fdone = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (!ended) begin
      errors++;
      $display("FAIL vec_timeout: op %b funct3 %b never returned to fetch", v.op, v.f3);
    end
    chk_int($sformatf("vec_cycles op=%b f3=%b", v.op, v.f3), cyc, v.cyc);
    chk_int($sformatf("vec_alu op=%b f3=%b", v.op, v.f3), int'(alu3), int'(v.alu3));
    chk_int($sformatf("vec_pcw op=%b f3=%b z=%b", v.op, v.f3, v.z), int'(pcw3), int'(v.pcw3));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    outs_t e;
    int    n;
    logic [6:0] ops [12];
    int    nops;
    logic [2:0] f3;

    //           op          f3      f7    z     fst mst cyc alu3     pcw3
    vt[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4, 4'b0001, 1'b0};
    vt[1]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4, 4'b0000, 1'b0};
    vt[2]  = '{7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0, 4, 4'b0111, 1'b0};
    vt[3]  = '{7'b0110011, 3'b011, 1'b0, 1'b1, 2, 0, 6, 4'b1001, 1'b0};
    vt[4]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, 7, 4'b0000, 1'b0};
    vt[5]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1, 6, 4'b0000, 1'b0};
    vt[6]  = '{7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 3, 4'b0001, 1'b1};
    vt[7]  = '{7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 3, 4'b0001, 1'b0};
    vt[8]  = '{7'b1100011, 3'b100, 1'b0, 1'b0, 0, 0, 3, 4'b1000, 1'b1};
    vt[9]  = '{7'b1100011, 3'b111, 1'b0, 1'b1, 0, 0, 3, 4'b1001, 1'b1};
    vt[10] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3, 4'b0001, 1'b0};
    vt[11] = '{7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, 4, 4'b0111, 1'b0};
    vt[12] = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4, 4'b0000, 1'b0};
    vt[13] = '{7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0, 4, 4'b0100, 1'b0};
    vt[14] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4, 4'b0000, 1'b1};
    vt[15] = '{7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, 5, 4'b0000, 1'b1};
    vt[16] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 4, 4'b0000, 1'b0};
    vt[17] = '{7'b0010111, 3'b000, 1'b0, 1'b0, 0, 0, 4, 4'b0000, 1'b0};
    vt[18] = '{7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, 4, 4'b0101, 1'b0};
    vt[19] = '{7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4, 4'b0011, 1'b0};

    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011,
            7'b0000000, 7'b1111111};
`ifdef CTRL_ILLEGAL_TRAP_EN
    nops = 10;
`else
    nops = 12;
`endif

    // reset: every output low regardless of inputs
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      zero = 1'($urandom); mem_ready = 1'($urandom);
      step_check("reset_outputs", '0);
    end
    reset = 1'b0;

    force_ready = 1'b1;
    run_model("sub_seq", 7'b0110011, 3'b000, 1'b1);

    for (int i = 0; i < 20; i++) run_vec(vt[i]);

    run_model("jalr_seq", 7'b1100111, 3'b000, 1'b0);

    // reset in the middle of a stalled store
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    n = 0;
    while (!MemWrite && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_int("reach_memwrite", n, 3);
    mem_ready = 1'b0;
    #4;
    e = '0; e.adr = 1'b1; e.mw = 1'b1;
    chk("memwrite_stall", e);
    reset = 1'b1;
    #1;
    chk("memwrite_reset_drop", '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = ab(2'b00, 2'b10, 3'b000, 4'b0000); e.res = 2'b10; e.mr = 1'b1;
    step_check("fetch_after_reset", e);

    force_ready = 1'b0;
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, nops - 1);
      f3 = 3'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (ops[n] == 7'b1100011 && f3[2:1] == 2'b01) f3 = 3'b000;
`endif
      run_model("random", ops[n], f3, 1'($urandom));
    end

    force_ready = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    run_model("illegal_pre", 7'b0000000, 3'b000, 1'b0);
    e = '0; e.ill = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom); zero = 1'($urandom);
      op = 7'($urandom);
      step_check("trap_hold", e);
    end
    reset = 1'b1;
    step_check("trap_reset", '0);
    reset = 1'b0;
    run_model("br_illegal_pre", 7'b1100011, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      step_check("br_trap_hold", e);
    end
`else
    e = ab(2'b00, 2'b10, 3'b000, 4'b0000); e.res = 2'b10; e.mr = 1'b1;
    run_model("illegal_nop", 7'b0000000, 3'b000, 1'b0);
    mem_ready = 1'b0;
    step_check("nop_back_to_fetch", e);
    run_model("br_f3_nop", 7'b1100011, 3'b011, 1'b0);
    mem_ready = 1'b0;
    step_check("br_nop_back_to_fetch", e);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
